svm_r_stream_loader: RTL and testbench

Feeds the combinational V3 SVM-R classifier (module top: 6 features x 4-bit in, 13-bit signed score out) from a serial feature stream, and returns its score on a valid/ready result stream. It is the producer and consumer end of the classifier's inp/out interface. It holds the packed feature vector stable while the classifier settles, then captures the score.

---
 rtl/svm_r_pkg.sv | 22 ++
 rtl/svm_r_stream_loader.sv | 141 ++++++++++++++
 tb/tb_svm_r_stream_loader.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/svm_r_pkg.sv
// Shared types and default sizing for the SVM-R stream loader.
package svm_r_pkg;

    localparam int NUM_FEAT = 6;
    localparam int FEAT_W   = 4;
    localparam int SCORE_W  = 13;

    // Loader sequencing states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        EVAL = 2'd2,
        HOLD = 2'd3
    } state_t;

    // Packed feature vector as presented to the classifier
    typedef logic [NUM_FEAT*FEAT_W-1:0] feat_vec_t;

    // Classifier score, two's complement
    typedef logic signed [SCORE_W-1:0] score_t;

endpackage

// File: rtl/svm_r_stream_loader.sv
// Serial feature stream -> packed classifier input, then captures the
// classifier score after a fixed settle window and offers it downstream.
module svm_r_stream_loader
    import svm_r_pkg::*;
#(
    parameter int NUM_FEAT    = svm_r_pkg::NUM_FEAT,
    parameter int FEAT_W      = svm_r_pkg::FEAT_W,
    parameter int SCORE_W     = svm_r_pkg::SCORE_W,
    parameter int EVAL_CYCLES = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [FEAT_W-1:0]          s_data,
    input  logic                       s_last,
    output logic [NUM_FEAT*FEAT_W-1:0] clf_inp,
    input  logic [SCORE_W-1:0]         clf_out,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [SCORE_W-1:0]         m_score,
    output logic                       m_err
);

    localparam int CNT_W = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
    localparam int VEC_W = NUM_FEAT * FEAT_W;
    localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(NUM_FEAT - 1);
    localparam logic [3:0]       SETTLE_END = 4'(EVAL_CYCLES - 1);

    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [3:0]         settle_reg;
    logic               s_ready_reg;
    logic               m_valid_reg;
    logic               m_err_reg;
    logic               err_pend_reg;
    logic [SCORE_W-1:0] m_score_reg;
    logic [VEC_W-1:0]   clf_inp_reg;
    logic [VEC_W-1:0]   clf_inp_next;

    logic beat_acc;
    logic last_beat;
    logic frame_err;

    // A beat is only consumed while loading; s_ready_reg is already low elsewhere
    // but the state term keeps the qualification explicit.
    assign beat_acc  = (state_reg == LOAD) && s_valid && s_ready_reg;

    // Vector closes on an explicit s_last or when the lane file is full.
    assign last_beat = s_last || (cnt_reg == LAST_IDX);

    // Early s_last and a missing s_last on the final lane are both framing errors.
    assign frame_err = s_last ? (cnt_reg != LAST_IDX) : (cnt_reg == LAST_IDX);

    // Per-lane next value: the addressed lane takes the beat, lanes beyond an
    // early s_last are cleared so stale features from a previous vector never
    // reach the classifier, and all other lanes hold.
    generate
        for (genvar gi = 0; gi < NUM_FEAT; gi++) begin : g_lane
            always_comb begin
                clf_inp_next[gi*FEAT_W +: FEAT_W] = clf_inp_reg[gi*FEAT_W +: FEAT_W];
                if (CNT_W'(gi) == cnt_reg) begin
                    clf_inp_next[gi*FEAT_W +: FEAT_W] = s_data;
                end else if (s_last && (CNT_W'(gi) > cnt_reg)) begin
                    clf_inp_next[gi*FEAT_W +: FEAT_W] = '0;
                end
            end
        end
    endgenerate

    // Sequencer: loads lanes, waits out the classifier settle time, captures the
    // score and holds it until the downstream handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            settle_reg   <= '0;
            s_ready_reg  <= 1'b0;
            m_valid_reg  <= 1'b0;
            m_err_reg    <= 1'b0;
            err_pend_reg <= 1'b0;
            m_score_reg  <= '0;
            clf_inp_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_reg   <= LOAD;
                    s_ready_reg <= 1'b1;
                    cnt_reg     <= '0;
                end

                LOAD: begin
                    if (beat_acc) begin
                        clf_inp_reg <= clf_inp_next;
                        if (last_beat) begin
                            state_reg    <= EVAL;
                            s_ready_reg  <= 1'b0;
                            settle_reg   <= '0;
                            err_pend_reg <= frame_err;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                end

                EVAL: begin
                    if (settle_reg == SETTLE_END) begin
                        m_score_reg <= clf_out;
                        m_err_reg   <= err_pend_reg;
                        m_valid_reg <= 1'b1;
                        state_reg   <= HOLD;
                    end else begin
                        settle_reg <= settle_reg + 1'b1;
                    end
                end

                HOLD: begin
                    if (m_ready) begin
                        m_valid_reg <= 1'b0;
                        cnt_reg     <= '0;
                        s_ready_reg <= 1'b1;
                        state_reg   <= LOAD;
                    end
                end

                default: begin
                    state_reg   <= IDLE;
                    s_ready_reg <= 1'b0;
                    m_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign s_ready = s_ready_reg;
    assign m_valid = m_valid_reg;
    assign m_score = m_score_reg;
    assign m_err   = m_err_reg;
    assign clf_inp = clf_inp_reg;

endmodule

// File: tb/tb_svm_r_stream_loader.sv
// Directed bench for the SVM-R stream loader. The classifier is stood in by a
// linear scoring function whose bias and weights reproduce the reference
// points for the zero, all-15, lane1+lane5 and lane4 vectors.
module tb_svm_r_stream_loader;
    import svm_r_pkg::*;

    localparam int EVAL = 3;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_last  = 1'b0;
    logic        m_ready = 1'b0;
    logic [3:0]  s_data  = 4'd0;
    feat_vec_t   clf_inp;
    logic [12:0] clf_out;
    logic [12:0] m_score;
    logic        s_ready;
    logic        m_valid;
    logic        m_err;

    int vectors     = 0;
    int miscompares = 0;
    int viol        = 0;
    int lat;
    int w [6] = '{5, -63, 10, 13, 88, -63};

    always #5 clk = ~clk;

    svm_r_stream_loader #(
        .NUM_FEAT   (6),
        .FEAT_W     (4),
        .SCORE_W    (13),
        .EVAL_CYCLES(EVAL)
    ) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_data (s_data),
        .s_last (s_last),
        .clf_inp(clf_inp),
        .clf_out(clf_out),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_score(m_score),
        .m_err  (m_err)
    );

    function automatic logic [12:0] model(input logic [23:0] v);
        int acc;
        acc = 1063;
        for (int i = 0; i < 6; i++) acc += w[i] * int'(v[i*4 +: 4]);
        return 13'(acc);
    endfunction

    assign clf_out = model(clf_inp);

    // s_ready must never coexist with a pending result
    always @(negedge clk) if (rst_n && s_ready && m_valid) viol++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_beat(input logic [3:0] d, input logic l);
        int n;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (s_ready) break;
            n++;
            if (n > 200) begin
                chk("beat_timeout", 1, 0);
                s_valid = 1'b0;
                s_last  = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_vec(input logic [23:0] v, input int n, input logic last_on_final);
        for (int i = 0; i < n; i++) send_beat(v[i*4 +: 4], (i == n - 1) && last_on_final);
    endtask

    task automatic wait_result(output int l);
        l = 0;
        while (1) begin
            @(negedge clk);
            l++;
            if (m_valid) break;
            if (s_ready) viol++;
            if (l > 200) begin
                chk("result_timeout", 1, 0);
                return;
            end
        end
    endtask

    task automatic handshake();
        @(negedge clk);
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        chk("valid_clears", 32'(m_valid), 0);
    endtask

    task automatic run_vec(input string tag, input logic [23:0] v, input int n,
                           input logic lst, input logic [12:0] exp_score,
                           input logic exp_err);
        send_vec(v, n, lst);
        wait_result(lat);
        chk({tag, "_score"}, 32'(m_score), 32'(exp_score));
        chk({tag, "_err"}, 32'(m_err), 32'(exp_err));
        $display("vec %s: inp=%h score=%0d err=%0b lat=%0d", tag, clf_inp,
                 $signed(m_score), m_err, lat);
        handshake();
    endtask

    initial begin
        logic [23:0] v;
        int          n;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_s_ready", 32'(s_ready), 0);
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_m_score", 32'(m_score), 0);
        chk("rst_m_err",   32'(m_err),   0);
        chk("rst_clf_inp", 32'(clf_inp), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_idle", 32'(s_ready), 1);

        // 1: all zeros, latency check
        send_vec(24'h000000, 6, 1'b1);
        wait_result(lat);
        chk("t1_latency", 32'(lat), 32'(EVAL + 1));
        chk("t1_score", 32'(m_score), 32'd1063);
        chk("t1_err", 32'(m_err), 0);
        $display("vec t1: score=%0d err=%0b lat=%0d", $signed(m_score), m_err, lat);
        handshake();

        // 2: all 15s
        run_vec("t2", 24'hFFFFFF, 6, 1'b1, 13'd913, 1'b0);

        // 3: negative score with downstream stall and a beat offered during HOLD
        send_vec(24'hF000F0, 6, 1'b1);
        wait_result(lat);
        chk("t3_score", 32'(m_score), 32'h1CC5);
        s_valid = 1'b1;
        s_data  = 4'd7;
        repeat (5) @(negedge clk);
        chk("t3_hold_valid", 32'(m_valid), 1);
        chk("t3_hold_score", 32'(m_score), 32'h1CC5);
        chk("t3_hold_inp",   32'(clf_inp), 32'hF000F0);
        chk("t3_hold_ready", 32'(s_ready), 0);
        $display("vec t3: score=%0d held 5 cycles", $signed(m_score));
        s_valid = 1'b0;
        handshake();

        // 4: early s_last after an all-15 vector, then missing s_last
        run_vec("t4a", 24'hFFFFFF, 6, 1'b1, 13'd913, 1'b0);
        send_vec(24'h0F0000, 5, 1'b1);
        wait_result(lat);
        chk("t4b_inp", 32'(clf_inp), 32'h0F0000);
        chk("t4b_score", 32'(m_score), 32'd2383);
        chk("t4b_err", 32'(m_err), 1);
        $display("vec t4b: inp=%h score=%0d err=%0b", clf_inp, $signed(m_score), m_err);
        handshake();
        run_vec("t4c", 24'h654321, 6, 1'b0, 13'd1086, 1'b1);

        // 5: random gaps and stalls
        for (int k = 0; k < 100; k++) begin
            v = 24'($urandom);
            for (int i = 0; i < 6; i++) begin
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
                send_beat(v[i*4 +: 4], i == 5);
            end
            wait_result(lat);
            n = $urandom_range(0, 3);
            repeat (n) begin
                @(negedge clk);
                s_valid = 1'($urandom_range(0, 1));
                s_data  = 4'($urandom);
            end
            s_valid = 1'b0;
            chk("t5_score", 32'(m_score), 32'(model(v)));
            chk("t5_inp", 32'(clf_inp), 32'(v));
            chk("t5_err", 32'(m_err), 0);
            $display("vec t5[%0d]: inp=%h score=%0d stall=%0d", k, v, $signed(m_score), n);
            handshake();
        end

        // 6: reset during EVAL
        send_vec(24'hFFFFFF, 6, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_eval_ready", 32'(s_ready), 0);
        chk("t6_eval_valid", 32'(m_valid), 0);
        chk("t6_eval_inp",   32'(clf_inp), 0);
        chk("t6_eval_score", 32'(m_score), 0);
        $display("vec t6a: reset in EVAL");
        @(negedge clk);
        rst_n = 1'b1;

        // reset during HOLD
        send_vec(24'hFFFFFF, 6, 1'b1);
        wait_result(lat);
        chk("t6_pre_score", 32'(m_score), 32'd913);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_hold_valid", 32'(m_valid), 0);
        chk("t6_hold_score", 32'(m_score), 0);
        chk("t6_hold_err",   32'(m_err), 0);
        $display("vec t6b: reset in HOLD");
        @(negedge clk);
        rst_n = 1'b1;
        run_vec("t6c", 24'hFFFFFF, 6, 1'b1, 13'd913, 1'b0);

        chk("ready_outside_load", 32'(viol), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
